// File: rtl/btn_debounce_scheduler_if.sv
// Button-side bundle for btn_debounce_scheduler: raw/mask inputs and the debounced outputs.
// The master modport drives the buttons; the slave modport is the scheduler.
interface btn_debounce_scheduler_if #(
    parameter int unsigned NUM_BTN = 4,
    parameter int unsigned SEL_W   = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_mask;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               busy;
    logic [SEL_W-1:0]   cur_sel;

    modport master (
        output btn_raw,
        output btn_mask,
        input  btn_level,
        input  btn_pulse,
        input  busy,
        input  cur_sel
    );

    modport slave (
        input  btn_raw,
        input  btn_mask,
        output btn_level,
        output btn_pulse,
        output busy,
        output cur_sel
    );
endinterface

// File: rtl/btn_debounce_scheduler.sv
// Debounces NUM_BTN buttons with one shared stability counter, granted round-robin to
// whichever enabled button currently disagrees with its debounced level.
module btn_debounce_scheduler #(
    parameter int unsigned NUM_BTN    = 4,
    parameter int unsigned MIN_CYCLES = 250000,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    btn_debounce_scheduler_if.slave       bus_io
);
    localparam int unsigned IdxW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MIN_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCount, StCommit} state_e;

    state_e             state_q;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] level_q, pulse_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   sel_q, ptr_q;
    logic               busy_q;

    logic [NUM_BTN-1:0] pending;
    logic               hit_found;
    logic [SEL_W-1:0]   hit_idx;
    logic [SEL_W-1:0]   ptr_inc;
    logic [IdxW-1:0]    sel_idx;

    assign pending = bus_io.btn_mask & (sync2_q ^ level_q);
    assign sel_idx = sel_q[IdxW-1:0];
    assign ptr_inc = (sel_q == SEL_W'(NUM_BTN - 1)) ? '0 : sel_q + SEL_W'(1);

    // First pending button at or after ptr, wrapping around.
    always_comb begin
        logic [IdxW-1:0] idx;
        idx       = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            idx = IdxW'((32'(ptr_q) + k) % NUM_BTN);
            if (!hit_found && pending[idx]) begin
                hit_found = 1'b1;
                hit_idx   = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= bus_io.btn_raw;
            sync2_q <= sync1_q;
            pulse_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (hit_found) begin
                        sel_q   <= hit_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCount;
                    end
                end
                StCount: begin
                    // Losing the pending condition (bounce or mask) forfeits the grant.
                    if (!pending[sel_idx]) begin
                        ptr_q   <= ptr_inc;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StCommit;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StCommit: begin
                    level_q[sel_idx] <= ~level_q[sel_idx];
                    pulse_q[sel_idx] <= ~level_q[sel_idx];
                    ptr_q            <= ptr_inc;
                    busy_q           <= 1'b0;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.btn_level = level_q;
    assign bus_io.btn_pulse = pulse_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.cur_sel   = sel_q;
endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// Bench for btn_debounce_scheduler: directed scenarios with literal expectations plus random
// bouncing stimulus, all compared every cycle against an ownership/hold-time model.
module tb_btn_debounce_scheduler;
    localparam int NB  = 4;
    localparam int MIN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    btn_debounce_scheduler_if #(.NUM_BTN(NB), .SEL_W(2)) bus_if ();

    btn_debounce_scheduler #(
        .NUM_BTN   (NB),
        .MIN_CYCLES(MIN),
        .CNT_W     (4),
        .SEL_W     (2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: owner = button holding the counter (-1 none), held = stable cycles counted so far.
    logic [NB-1:0] m_s1, m_s2, m_level, m_pulse, m_pend;
    int            m_owner, m_held, m_ptr, m_pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
            m_owner = -1; m_held = 0; m_ptr = 0;
        end else begin
            m_pend  = bus_if.btn_mask & (m_s2 ^ m_level);
            m_pulse = '0;
            if (m_owner < 0) begin
                m_pick = -1;
                for (int k = NB - 1; k >= 0; k--)
                    if (m_pend[(m_ptr + k) % NB]) m_pick = (m_ptr + k) % NB;
                if (m_pick >= 0) begin
                    m_owner = m_pick;
                    m_held  = 0;
                end
            end else if (m_held < MIN) begin
                if (!m_pend[m_owner]) begin
                    m_ptr   = (m_owner + 1) % NB;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end else begin
                m_level[m_owner] = ~m_level[m_owner];
                m_pulse[m_owner] = m_level[m_owner];
                m_ptr   = (m_owner + 1) % NB;
                m_owner = -1;
            end
            m_s2 = m_s1;
            m_s1 = bus_if.btn_raw;
        end
    end

    always @(negedge clk) begin
        check("level", bus_if.btn_level, m_level);
        check("pulse", bus_if.btn_pulse, m_pulse);
        check("busy", bus_if.busy, m_owner >= 0);
        check("pulse_onehot", $onehot0(bus_if.btn_pulse), 1);
        if (m_owner >= 0) check("cur_sel", bus_if.cur_sel, m_owner);
    end

    task automatic do_reset();
        @(negedge clk);
        bus_if.btn_raw  = '0;
        bus_if.btn_mask = '1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    int busy_cnt, pcnt;
    int pe[$];
    logic [NB-1:0] pv[$];

    initial begin
        bus_if.btn_raw  = '0;
        bus_if.btn_mask = '1;
        do_reset();
        check("rst_level", bus_if.btn_level, 0);
        check("rst_pulse", bus_if.btn_pulse, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_cur_sel", bus_if.cur_sel, 0);

        // Clean press on button 1.
        @(negedge clk);
        bus_if.btn_raw = 4'b0010;
        busy_cnt = 0;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            if (bus_if.busy) busy_cnt++;
            if (e == 11) check("t1_level_e11", bus_if.btn_level, 4'b0000);
            if (e == 12) begin
                check("t1_pulse_e12", bus_if.btn_pulse, 4'b0010);
                check("t1_level_e12", bus_if.btn_level, 4'b0010);
            end
            if (e == 13) check("t1_pulse_e13", bus_if.btn_pulse, 4'b0000);
        end
        check("t1_busy_cycles", busy_cnt, 9);

        // Bounce on button 2: high 5, low 3, then steady high.
        bus_if.btn_raw[2] = 1'b1;
        pcnt = 0; busy_cnt = 0;
        repeat (5) begin @(negedge clk); if (bus_if.btn_pulse != 0) pcnt++; if (bus_if.busy) busy_cnt++; end
        bus_if.btn_raw[2] = 1'b0;
        repeat (3) begin @(negedge clk); if (bus_if.btn_pulse != 0) pcnt++; end
        check("t2_granted", busy_cnt > 0, 1);
        check("t2_aborted", bus_if.busy, 0);
        bus_if.btn_raw[2] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e < 12 && bus_if.btn_pulse != 0) pcnt++;
            if (e == 12) begin
                check("t2_pulse", bus_if.btn_pulse, 4'b0100);
                check("t2_level", bus_if.btn_level, 4'b0110);
            end
        end
        check("t2_no_early_pulse", pcnt, 0);

        // Contention from ptr=0.
        do_reset();
        bus_if.btn_raw = 4'b1011;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (bus_if.btn_pulse != 0) begin pe.push_back(e); pv.push_back(bus_if.btn_pulse); end
        end
        check("t3_pulse_count", pe.size(), 3);
        if (pe.size() == 3) begin
            check("t3_e0", pe[0], 12); check("t3_v0", pv[0], 4'b0001);
            check("t3_e1", pe[1], 22); check("t3_v1", pv[1], 4'b0010);
            check("t3_e2", pe[2], 32); check("t3_v2", pv[2], 4'b1000);
        end

        // Release of button 0.
        bus_if.btn_raw = 4'b1010;
        pcnt = 0;
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            if (bus_if.btn_pulse != 0) pcnt++;
            if (e == 11) check("t4_level_e11", bus_if.btn_level, 4'b1011);
            if (e == 12) check("t4_level_e12", bus_if.btn_level, 4'b1010);
        end
        check("t4_no_pulse", pcnt, 0);

        // Mask drop mid-count on button 3.
        do_reset();
        bus_if.btn_raw = 4'b1000;
        repeat (6) @(negedge clk);
        check("t5_busy", bus_if.busy, 1);
        check("t5_sel", bus_if.cur_sel, 3);
        bus_if.btn_mask = 4'b0111;
        pcnt = 0;
        repeat (15) begin @(negedge clk); if (bus_if.btn_pulse != 0) pcnt++; end
        check("t5_level_held", bus_if.btn_level, 4'b0000);
        check("t5_idle", bus_if.busy, 0);
        check("t5_no_pulse", pcnt, 0);
        bus_if.btn_mask = 4'b1111;
        repeat (15) @(negedge clk);
        check("t5_unmasked_level", bus_if.btn_level, 4'b1000);

        // Reset mid-count.
        bus_if.btn_raw = 4'b1001;
        repeat (6) @(negedge clk);
        check("t6_busy", bus_if.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_level", bus_if.btn_level, 0);
        check("t6_rst_pulse", bus_if.btn_pulse, 0);
        check("t6_rst_busy", bus_if.busy, 0);
        check("t6_rst_sel", bus_if.cur_sel, 0);
        @(negedge clk);
        bus_if.btn_raw = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        pcnt = 0;
        repeat (20) begin @(negedge clk); if (bus_if.btn_pulse != 0) pcnt++; end
        check("t6_no_pulse", pcnt, 0);
        check("t6_level", bus_if.btn_level, 0);

        // Random bouncing buttons and mask changes; the per-cycle compare does the checking.
        for (int c = 0; c < 6000; c++) begin
            int b;
            @(negedge clk);
            b = $urandom_range(0, NB - 1);
            if (((c / 300) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0))
                bus_if.btn_raw[b] = ~bus_if.btn_raw[b];
            if ($urandom_range(0, 199) == 0)
                bus_if.btn_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if (c == 3000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        bus_if.btn_mask = '1;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
